// File: rtl/uart_boot_pkg.sv
// Shared constants and FSM state encoding for the UART boot image streamer.
// The CSUM state only exists when BOOT_CHECKSUM_EN is defined.
package uart_boot_pkg;

    localparam logic [7:0] SYNC_DEFAULT    = 8'hA5;
    localparam int         UART_FRAME_BITS = 10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FIN
    } state_t;

endpackage

// File: rtl/uart_boot_streamer_if.sv
// Word-memory read port between the boot streamer (master) and the image memory (slave).
interface uart_boot_streamer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_adr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_adr, output mem_rd, input mem_data);
    modport slave  (input mem_adr, input mem_rd, output mem_data);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with down-counting baud timer. ready is also raised in the final
// stop-bit cycle so a pending byte starts with no idle time on the line.
module uart_tx_byte
    import uart_boot_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);
    localparam int                CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]     BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    logic                       active_q, active_d;
    logic [CW-1:0]              baud_q, baud_d;
    logic [3:0]                 bit_q, bit_d;
    logic [UART_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                       last_tick;

    assign last_tick = active_q && (baud_q == '0) && (bit_q == 4'd0);
    assign ready_o   = !active_q || last_tick;
    // Idle level comes from active_q alone, so async reset drives the line high at once.
    assign tx_o      = active_q ? shreg_q[0] : 1'b1;

    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        if (active_q) begin
            if (baud_q == '0) begin
                baud_d = BAUD_LAST;
                if (bit_q == 4'd0) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q - 4'd1;
                    shreg_d = {1'b1, shreg_q[UART_FRAME_BITS-1:1]};
                end
            end else begin
                baud_d = baud_q - CW'(1);
            end
        end
        if (valid_i && ready_o) begin
            active_d = 1'b1;
            baud_d   = BAUD_LAST;
            bit_d    = BIT_LAST;
            shreg_d  = {1'b1, data_i, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shreg_q  <= '1;
        end else if (ce_i) begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
        end
    end

endmodule

// File: rtl/uart_boot_streamer.sv
// Streams SYNC, 16-bit word count and a memory image over UART TX for the boot loader.
// Define BOOT_CHECKSUM_EN to append a mod-256 checksum of all bytes after SYNC.
module uart_boot_streamer
    import uart_boot_pkg::*;
#(
    parameter int         CLK_DIV = 868,
    parameter int         DATA_W  = 16,
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_adr_i,
    input  logic [15:0]         word_cnt_i,
    uart_boot_streamer_if.master mem,
    output logic                tx_o,
    output logic                busy_o,
    output logic                done_o
);
    localparam int                NB      = DATA_W / 8;
    localparam int                BI_W    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BI_W-1:0]   BI_LAST = BI_W'(NB - 1);
`ifdef BOOT_CHECKSUM_EN
    localparam state_t            TAIL    = ST_CSUM;
`else
    localparam state_t            TAIL    = ST_FIN;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [BI_W-1:0]     bidx_q, bidx_d;
    logic                done_q, done_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                tx_valid;
    logic [7:0]          tx_data;
    logic                tx_ready;
    logic                accept;

    assign accept      = tx_valid && tx_ready;
    assign mem.mem_adr = adr_q;
    assign mem.mem_rd  = (state_q == ST_FETCH);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        bidx_d   = bidx_q;
        done_d   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = SYNC;
`ifdef BOOT_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // done_q blocks a start arriving in the same cycle as the done pulse.
                if (start_i && !done_q) begin
                    adr_d   = base_adr_i;
                    cnt_d   = word_cnt_i;
                    state_d = ST_SYNC;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC;
                if (accept) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                tx_valid = 1'b1;
                tx_data  = cnt_q[15:8];
                if (accept) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                tx_valid = 1'b1;
                tx_data  = cnt_q[7:0];
                if (accept) state_d = (cnt_q == 16'd0) ? TAIL : ST_FETCH;
            end
            ST_FETCH: begin
                adr_d   = adr_q + ADDR_W'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                word_d  = mem.mem_data;
                bidx_d  = BI_LAST;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = word_q[bidx_q*8 +: 8];
                // The next fetch runs while this word's last byte is still on the line.
                if (accept) begin
                    if (bidx_q == '0) state_d = (cnt_q != 16'd0) ? ST_FETCH : TAIL;
                    else              bidx_d  = bidx_q - BI_W'(1);
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (accept) state_d = ST_FIN;
            end
`endif
            ST_FIN: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef BOOT_CHECKSUM_EN
        if (accept && (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_SEND}))
            csum_d = csum_q + tx_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            cnt_q   <= 16'd0;
            word_q  <= '0;
            bidx_q  <= '0;
            done_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else if (ce_i) begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            done_q  <= done_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx_byte (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce_i    (ce_i),
        .valid_i (tx_valid),
        .data_i  (tx_data),
        .ready_o (tx_ready),
        .tx_o    (tx_o)
    );

endmodule
